mbssoc_mailbox: RTL and testbench



---
 rtl/mbssoc_mailbox.sv | 164 ++++++++++++++++
 tb/tb_mbssoc_mailbox.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mbssoc_mailbox.sv
// Inter-processor mailbox: one inbox FIFO per core behind the SoC bus,
// with registered read data and a per-core interrupt while an inbox holds data.
module mbssoc_mailbox #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h0000_FF00,
    parameter int                    DEPTH      = 4,
    parameter int                    CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ram_re,
    input  logic                  ram_we,
    input  logic                  wr_invalid,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  cpu_sel,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_oe,
    output logic                  ack,
    output logic [1:0]            int_req
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WIN_HI = BASE_ADDR + ADDR_WIDTH'(15);

    typedef enum logic [1:0] {
        R_TX = 2'd0,
        R_RX = 2'd1,
        R_ST = 2'd2,
        R_CT = 2'd3
    } reg_e;

    logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];
    logic [PW-1:0]         wptr_q [2];
    logic [PW-1:0]         wptr_d [2];
    logic [PW-1:0]         rptr_q [2];
    logic [PW-1:0]         rptr_d [2];
    logic [CNT_W-1:0]      cnt_q [2];
    logic [CNT_W-1:0]      cnt_d [2];
    logic [1:0]            ie_q, ie_d;
    logic [1:0]            ovf_q, ovf_d;
    logic [1:0]            unf_q, unf_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  oe_q, oe_d;
    logic                  ack_q, ack_d;

    logic [1:0]            full, empty;
    logic                  own, oth;
    logic                  hit, wr_ok, rd, push;
    reg_e                  sel;
    logic [DATA_WIDTH-1:0] status;

    // Register select works on addr[3:2] alone, so unaligned offsets alias.
    assign sel = reg_e'(addr[3:2] - BASE_ADDR[3:2]);
    assign own = cpu_sel;
    assign oth = ~cpu_sel;
    assign hit = (addr >= BASE_ADDR) && (addr <= WIN_HI) && (ram_re || ram_we);
    assign wr_ok = hit && ram_we && !wr_invalid;
    assign rd = hit && ram_re && !ram_we;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            full[k]  = (cnt_q[k] == CNT_W'(DEPTH));
            empty[k] = (cnt_q[k] == '0);
        end
    end

    always_comb begin
        status = '0;
        status[CNT_W-1:0] = cnt_q[own];
        status[8]  = full[own];
        status[9]  = empty[own];
        status[10] = ovf_q[own];
        status[11] = unf_q[own];
        status[16] = ie_q[own];
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        ie_d    = ie_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        rdata_d = rdata_q;
        oe_d    = rd;
        ack_d   = hit;
        push    = 1'b0;
        if (wr_ok) begin
            unique case (sel)
                R_TX: begin
                    if (full[oth]) begin
                        ovf_d[own] = 1'b1;
                    end else begin
                        push        = 1'b1;
                        wptr_d[oth] = wptr_q[oth] + 1'b1;
                        cnt_d[oth]  = cnt_q[oth] + 1'b1;
                    end
                end
                R_CT: ie_d[own] = wdata[0];
                default: ;
            endcase
        end
        if (rd) begin
            unique case (sel)
                R_TX: rdata_d = '0;
                R_RX: begin
                    if (empty[own]) begin
                        rdata_d    = '0;
                        unf_d[own] = 1'b1;
                    end else begin
                        rdata_d     = mem_q[own][rptr_q[own]];
                        rptr_d[own] = rptr_q[own] + 1'b1;
                        cnt_d[own]  = cnt_q[own] - 1'b1;
                    end
                end
                R_ST: begin
                    rdata_d    = status;
                    ovf_d[own] = 1'b0;
                    unf_d[own] = 1'b0;
                end
                R_CT: rdata_d = DATA_WIDTH'(ie_q[own]);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[oth][wptr_q[oth]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '{default: '0};
            rptr_q  <= '{default: '0};
            cnt_q   <= '{default: '0};
            ie_q    <= '0;
            ovf_q   <= '0;
            unf_q   <= '0;
            rdata_q <= '0;
            oe_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ie_q    <= ie_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            rdata_q <= rdata_d;
            oe_q    <= oe_d;
            ack_q   <= ack_d;
        end
    end

    assign rdata    = rdata_q;
    assign rdata_oe = oe_q;
    assign ack      = ack_q;
    assign int_req  = ie_q & ~empty;

endmodule

// File: tb/tb_mbssoc_mailbox.sv
// Bench for mbssoc_mailbox: directed scenarios plus random traffic
// against a queue-based model of the two inboxes.
module tb_mbssoc_mailbox;

    localparam logic [31:0] BASE  = 32'h0000_FF00;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_re, ram_we, wr_invalid, cpu_sel;
    logic [31:0] addr, wdata, rdata;
    logic        rdata_oe, ack;
    logic [1:0]  int_req;

    always #5 clk = ~clk;

    mbssoc_mailbox #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .wr_invalid(wr_invalid),
        .addr      (addr),
        .cpu_sel   (cpu_sel),
        .wdata     (wdata),
        .rdata     (rdata),
        .rdata_oe  (rdata_oe),
        .ack       (ack),
        .int_req   (int_req)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit [1:0]    m_ie, m_ovf, m_unf;
    logic [31:0] m_rd;

    function automatic int qsize(input bit k);
        return k ? q1.size() : q0.size();
    endfunction

    function automatic logic [1:0] m_int();
        logic [1:0] r;
        r[0] = m_ie[0] && (q0.size() != 0);
        r[1] = m_ie[1] && (q1.size() != 0);
        return r;
    endfunction

    task automatic m_reset();
        q0.delete();
        q1.delete();
        m_ie  = '0;
        m_ovf = '0;
        m_unf = '0;
        m_rd  = '0;
    endtask

    task automatic acc(input bit cpu, input bit re, input bit we,
                       input bit inv, input logic [31:0] a,
                       input logic [31:0] wd);
        bit          hit, e_oe;
        int          off, n;
        logic [31:0] v;
        hit  = (a >= BASE) && (a <= BASE + 32'd15) && (re || we);
        off  = int'(a - BASE) / 4;
        e_oe = hit && re && !we;
        if (hit && we && !inv) begin
            if (off == 0) begin
                if (qsize(!cpu) == DEPTH) m_ovf[cpu] = 1'b1;
                else if (cpu) q0.push_back(wd);
                else q1.push_back(wd);
            end else if (off == 3) begin
                m_ie[cpu] = wd[0];
            end
        end else if (e_oe) begin
            n = qsize(cpu);
            case (off)
                0: m_rd = 0;
                1: begin
                    if (n == 0) begin
                        m_rd = 0;
                        m_unf[cpu] = 1'b1;
                    end else begin
                        m_rd = cpu ? q1.pop_front() : q0.pop_front();
                    end
                end
                2: begin
                    v = n;
                    v += (n == DEPTH) ? 32'h100 : 32'h0;
                    v += (n == 0) ? 32'h200 : 32'h0;
                    v += m_ovf[cpu] ? 32'h400 : 32'h0;
                    v += m_unf[cpu] ? 32'h800 : 32'h0;
                    v += m_ie[cpu] ? 32'h1_0000 : 32'h0;
                    m_rd = v;
                    m_ovf[cpu] = 1'b0;
                    m_unf[cpu] = 1'b0;
                end
                default: m_rd = {31'b0, m_ie[cpu]};
            endcase
        end
        @(posedge clk);
        #1;
        chk("idle_ack", {31'b0, ack}, 32'd0);
        chk("idle_oe", {31'b0, rdata_oe}, 32'd0);
        cpu_sel    = cpu;
        ram_re     = re;
        ram_we     = we;
        wr_invalid = inv;
        addr       = a;
        wdata      = wd;
        @(posedge clk);
        #1;
        ram_re     = 1'b0;
        ram_we     = 1'b0;
        wr_invalid = 1'b0;
        chk("ack", {31'b0, ack}, {31'b0, hit});
        chk("rdata_oe", {31'b0, rdata_oe}, {31'b0, e_oe});
        chk("rdata", rdata, m_rd);
        chk("int_req", {30'b0, int_req}, {30'b0, m_int()});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        bit          re, we, inv, cpu;
        int          r;
        ram_re = 0; ram_we = 0; wr_invalid = 0;
        cpu_sel = 0; addr = '0; wdata = '0;
        do_reset();
        #1;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_oe", {31'b0, rdata_oe}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_int", {30'b0, int_req}, 32'd0);

        acc(0, 0, 1, 0, BASE + 32'hC, 32'd1);
        acc(0, 0, 1, 0, BASE, 32'hDEAD_BEEF);
        chk("int_ie1_off", {30'b0, int_req}, 32'd0);
        acc(1, 1, 0, 0, BASE + 32'h8, 32'd0);
        chk("cnt1_one", rdata & 32'h7, 32'd1);
        acc(1, 0, 1, 0, BASE + 32'hC, 32'd1);
        chk("int_rise", {30'b0, int_req}, 32'd2);
        acc(1, 1, 0, 0, BASE + 32'h4, 32'd0);
        chk("rx_beef", rdata, 32'hDEAD_BEEF);
        chk("int_fall", {30'b0, int_req}, 32'd0);
        acc(1, 1, 0, 0, BASE + 32'h8, 32'd0);
        chk("st_empty_ie", rdata, 32'h0001_0200);

        for (int i = 1; i <= 5; i++) acc(0, 0, 1, 0, BASE, i);
        acc(0, 1, 0, 0, BASE + 32'h8, 32'd0);
        chk("ovf_set", rdata & 32'h400, 32'h400);
        acc(0, 1, 0, 0, BASE + 32'h8, 32'd0);
        chk("ovf_clr", rdata & 32'h400, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            acc(1, 1, 0, 0, BASE + 32'h4, 32'd0);
            chk("pop_order", rdata, i);
        end
        acc(1, 1, 0, 0, BASE + 32'h4, 32'd0);
        chk("pop_empty", rdata, 32'd0);
        acc(1, 1, 0, 0, BASE + 32'h8, 32'd0);
        chk("unf_set", rdata & 32'h800, 32'h800);

        for (int i = 0; i < 10; i++) begin
            acc(1, 0, 1, 0, BASE, $urandom);
            acc(0, 1, 0, 0, BASE + 32'h8, 32'd0);
            acc(0, 1, 0, 0, BASE + 32'h4, 32'd0);
        end

        acc(0, 0, 1, 1, BASE, 32'h1234_5678);
        acc(1, 1, 0, 0, BASE + 32'h8, 32'd0);
        acc(0, 1, 0, 0, BASE + 32'h10, 32'd0);
        acc(0, 0, 1, 0, BASE - 32'd4, 32'd7);
        acc(0, 1, 1, 0, BASE + 32'h5, 32'd9);

        // reset lands between a RX strobe and its response
        acc(0, 0, 1, 0, BASE, 32'hCAFE_0001);
        @(posedge clk);
        #1;
        cpu_sel = 1; ram_re = 1; addr = BASE + 32'h4;
        @(posedge clk);
        #1;
        ram_re = 0;
        rst_n  = 1'b0;
        m_reset();
        #1;
        chk("mid_rst_ack", {31'b0, ack}, 32'd0);
        chk("mid_rst_oe", {31'b0, rdata_oe}, 32'd0);
        chk("mid_rst_int", {30'b0, int_req}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acc(0, 1, 0, 0, BASE + 32'h8, 32'd0);
        acc(1, 1, 0, 0, BASE + 32'h8, 32'd0);

        for (int i = 0; i < 400; i++) begin
            cpu = 1'($urandom);
            r = int'($urandom_range(0, 11));
            v = {$urandom_range(0, 3), 2'b00};
            if ($urandom_range(0, 7) == 0) v[1:0] = 2'($urandom);
            if (r < 9) v = BASE + v;
            else if (r == 9) v = BASE + 32'h10 + v;
            else if (r == 10) v = BASE - 32'd4;
            else v = BASE;
            we  = ($urandom_range(0, 1) == 1);
            re  = !we || ($urandom_range(0, 9) == 0);
            inv = ($urandom_range(0, 7) == 0);
            acc(cpu, re, we, inv, v, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
